// File: rtl/mem_stage.sv
// Purpose : ARM pipeline memory stage; maps the ALU result onto an SRAM word address and runs a fixed-length SRAM load/store.
// Latency : a request seen at cycle 0 keeps o_Freeze high for cycles 0..WAIT_CYCLES; load data appears on o_Data_Memory from cycle WAIT_CYCLES+1.
// Backpressure: o_Freeze holds IF/ID/EXE and their pipeline registers until the access finishes; non-memory instructions never stall.
//
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   i_Pc, i_Sig_*, i_ALU_Result,
//   i_Destination                   - EXE->MEM register contents, copied straight to the o_* pass-through outputs
//   i_Val_Rm                        - store data
//   i_Sram_Read_Data                - SRAM read bus
//   o_Data_Memory                   - last loaded word (registered)
//   o_Freeze                        - stall request to the upstream stages
//   o_Sram_Address/_Write_Data      - registered SRAM word address and store data
//   o_Sram_Write_Enable/_Output_Enable - SRAM write and read strobes
module mem_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 17,
    parameter int BASE_ADDRESS = 1024,
    parameter int WAIT_CYCLES  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_Pc,
    input  logic                  i_Sig_Write_Back_Enable,
    input  logic                  i_Sig_Memory_Read_Enable,
    input  logic                  i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_ALU_Result,
    input  logic [DATA_WIDTH-1:0] i_Val_Rm,
    input  logic [3:0]            i_Destination,
    input  logic [DATA_WIDTH-1:0] i_Sram_Read_Data,
    output logic [DATA_WIDTH-1:0] o_Pc,
    output logic                  o_Sig_Write_Back_Enable,
    output logic                  o_Sig_Memory_Read_Enable,
    output logic [DATA_WIDTH-1:0] o_ALU_Result,
    output logic [3:0]            o_Destination,
    output logic [DATA_WIDTH-1:0] o_Data_Memory,
    output logic                  o_Freeze,
    output logic [ADDR_WIDTH-1:0] o_Sram_Address,
    output logic [DATA_WIDTH-1:0] o_Sram_Write_Data,
    output logic                  o_Sram_Write_Enable,
    output logic                  o_Sram_Output_Enable
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             access_is_write;
    logic             req;

    // Byte address relative to the SRAM window; out-of-window addresses simply wrap.
    logic [DATA_WIDTH-1:0] byte_offset;
    logic [ADDR_WIDTH-1:0] word_address;
    logic                  unused_offset_bits;

    assign req                = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
    assign byte_offset        = i_ALU_Result - DATA_WIDTH'(BASE_ADDRESS);
    assign word_address       = byte_offset[ADDR_WIDTH+1:2];
    assign unused_offset_bits = ^{byte_offset[DATA_WIDTH-1:ADDR_WIDTH+2], byte_offset[1:0]};

    // Pass-through; mem_stage_reg does the registering.
    assign o_Pc                     = i_Pc;
    assign o_Sig_Write_Back_Enable  = i_Sig_Write_Back_Enable;
    assign o_Sig_Memory_Read_Enable = i_Sig_Memory_Read_Enable;
    assign o_ALU_Result             = i_ALU_Result;
    assign o_Destination            = i_Destination;

    // Stall starts combinationally on the request cycle and drops in DONE so the
    // pipeline advances on the DONE edge.
    assign o_Freeze = ~reset & (((state == IDLE) & req) | (state == ACCESS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= IDLE;
            count                <= '0;
            access_is_write      <= 1'b0;
            o_Data_Memory        <= '0;
            o_Sram_Address       <= '0;
            o_Sram_Write_Data    <= '0;
            o_Sram_Write_Enable  <= 1'b0;
            o_Sram_Output_Enable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both enables are set.
                        o_Sram_Address       <= word_address;
                        o_Sram_Write_Data    <= i_Val_Rm;
                        access_is_write      <= i_Sig_Memory_Write_Enable;
                        count                <= '0;
                        o_Sram_Write_Enable  <= i_Sig_Memory_Write_Enable;
                        o_Sram_Output_Enable <= ~i_Sig_Memory_Write_Enable;
                        state                <= ACCESS;
                    end
                end
                ACCESS: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST_COUNT) begin
                        o_Sram_Write_Enable  <= 1'b0;
                        o_Sram_Output_Enable <= 1'b0;
                        if (!access_is_write) begin
                            o_Data_Memory <= i_Sram_Read_Data;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // The stalled request is still on the inputs here; skipping
                    // IDLE for one cycle keeps it from starting a second access.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int W    = 5;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        wb_en, rd_en, wr_en;
    logic [31:0] alu, val_rm, sram_rdata;
    logic [3:0]  dest;

    logic [31:0] o_pc, o_alu, o_dmem, o_sram_wdata;
    logic        o_wb, o_rd, o_freeze, o_we, o_oe;
    logic [3:0]  o_dest;
    logic [16:0] o_sram_addr;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                      (clk),
        .reset                    (reset),
        .i_Pc                     (pc),
        .i_Sig_Write_Back_Enable  (wb_en),
        .i_Sig_Memory_Read_Enable (rd_en),
        .i_Sig_Memory_Write_Enable(wr_en),
        .i_ALU_Result             (alu),
        .i_Val_Rm                 (val_rm),
        .i_Destination            (dest),
        .i_Sram_Read_Data         (sram_rdata),
        .o_Pc                     (o_pc),
        .o_Sig_Write_Back_Enable  (o_wb),
        .o_Sig_Memory_Read_Enable (o_rd),
        .o_ALU_Result             (o_alu),
        .o_Destination            (o_dest),
        .o_Data_Memory            (o_dmem),
        .o_Freeze                 (o_freeze),
        .o_Sram_Address           (o_sram_addr),
        .o_Sram_Write_Data        (o_sram_wdata),
        .o_Sram_Write_Enable      (o_we),
        .o_Sram_Output_Enable     (o_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int freeze_cnt = 0, oe_cnt = 0, we_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Timeline model: an accepted access at cycle t0 stalls cycles t0..t0+W,
    // strobes cycles t0+1..t0+W, returns data from t0+W+1, and the stage is
    // free to accept again at t0+W+2.
    // ---------------------------------------------------------------------
    int          cyc = 0;
    int          t0  = -1;
    int          ph;
    bit          mvalid = 0;
    bit          m_wr;
    logic [16:0] pend_addr, exp_addr;
    logic [31:0] pend_wdata, exp_wdata, exp_dmem;
    logic        exp_freeze, exp_oe, exp_we;

    always @(negedge clk) begin
        if (t0 < 0 && (rd_en || wr_en) && !reset && mvalid) begin
            t0         = cyc;
            m_wr       = wr_en;
            pend_addr  = 17'((alu - 32'(BASE)) >> 2);
            pend_wdata = val_rm;
        end
        ph         = (t0 >= 0) ? cyc - t0 : -1;
        exp_freeze = !reset && ph >= 0 && ph <= W;
        exp_oe     = ph >= 1 && ph <= W && !m_wr;
        exp_we     = ph >= 1 && ph <= W && m_wr;

        if (mvalid) begin
            check("pc_pass",   o_pc, pc);
            check("wb_pass",   32'(o_wb), 32'(wb_en));
            check("rd_pass",   32'(o_rd), 32'(rd_en));
            check("alu_pass",  o_alu, alu);
            check("dest_pass", 32'(o_dest), 32'(dest));
            check("freeze",    32'(o_freeze), 32'(exp_freeze));
            check("oe",        32'(o_oe), 32'(exp_oe));
            check("we",        32'(o_we), 32'(exp_we));
            check("dmem",      o_dmem, exp_dmem);
            check("sram_addr", 32'(o_sram_addr), 32'(exp_addr));
            check("sram_wdat", o_sram_wdata, exp_wdata);
            freeze_cnt += int'(o_freeze);
            oe_cnt     += int'(o_oe);
            we_cnt     += int'(o_we);
        end

        if (reset) begin
            t0        = -1;
            exp_dmem  = '0;
            exp_addr  = '0;
            exp_wdata = '0;
            mvalid    = 1;
        end else begin
            if (ph == 0) begin
                exp_addr  = pend_addr;
                exp_wdata = pend_wdata;
            end
            if (ph == W && !m_wr) exp_dmem = sram_rdata;
            if (ph == W + 1) t0 = -1;
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        freeze_cnt = 0;
        oe_cnt     = 0;
        we_cnt     = 0;
    endtask

    // Drive one memory op, hold it through DONE (W+2 cycles), then drop it.
    task automatic mem_op(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] v, input logic [31:0] rdat, input logic [31:0] p);
        rd_en = rd; wr_en = wr; alu = a; val_rm = v; sram_rdata = rdat; pc = p;
        wb_en = rd; dest = p[5:2];
        step(W + 2);
    endtask

    task automatic idle(input int n);
        rd_en = 0; wr_en = 0; wb_en = 0;
        step(n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; pc = 32'h100; wb_en = 1; rd_en = 1; wr_en = 0;
        alu = 32'h408; val_rm = 0; sram_rdata = 32'h0; dest = 4'h3;

        // Reset held with a load request present.
        step(2);
        reset = 0; rd_en = 0; wb_en = 0;
        step(1);
        check("rst_freeze", 32'(o_freeze), 32'h0);
        check("rst_oe",     32'(o_oe), 32'h0);
        check("rst_we",     32'(o_we), 32'h0);
        check("rst_dmem",   o_dmem, 32'h0);

        // Load from 0x408 -> word 2.
        clr_counts();
        mem_op(1, 0, 32'h408, 32'h0, 32'hDEADBEEF, 32'h200);
        idle(1);
        check("ld_freeze_cycles", 32'(freeze_cnt), 32'd6);
        check("ld_oe_cycles",     32'(oe_cnt), 32'd5);
        check("ld_we_cycles",     32'(we_cnt), 32'd0);
        check("ld_addr",          32'(o_sram_addr), 32'd2);
        check("ld_data",          o_dmem, 32'hDEADBEEF);

        // Store to 0x40C -> word 3; read bus carries junk that must not be taken.
        clr_counts();
        mem_op(0, 1, 32'h40C, 32'h12345678, 32'hCAFEF00D, 32'h204);
        idle(1);
        check("st_freeze_cycles", 32'(freeze_cnt), 32'd6);
        check("st_we_cycles",     32'(we_cnt), 32'd5);
        check("st_oe_cycles",     32'(oe_cnt), 32'd0);
        check("st_addr",          32'(o_sram_addr), 32'd3);
        check("st_wdata",         o_sram_wdata, 32'h12345678);
        check("st_dmem_kept",     o_dmem, 32'hDEADBEEF);

        // Non-memory op: no stall, pass-through in the same cycle.
        clr_counts();
        alu = 32'h55; pc = 32'h208; wb_en = 1; dest = 4'h7;
        step(4);
        check("nm_alu_pass",      o_alu, 32'h55);
        check("nm_dest_pass",     32'(o_dest), 32'h7);
        check("nm_freeze_cycles", 32'(freeze_cnt), 32'd0);
        check("nm_strobe_cycles", 32'(oe_cnt + we_cnt), 32'd0);

        // Back-to-back load then store; the store starts the cycle after DONE.
        clr_counts();
        mem_op(1, 0, 32'h410, 32'h0, 32'h0BADF00D, 32'h20C);
        mem_op(0, 1, 32'h414, 32'hA5A5A5A5, 32'h0, 32'h210);
        idle(2);
        check("b2b_freeze_cycles", 32'(freeze_cnt), 32'd12);
        check("b2b_dmem",          o_dmem, 32'h0BADF00D);
        check("b2b_addr",          32'(o_sram_addr), 32'd5);

        // Both enables: treated as a write, load data register untouched.
        clr_counts();
        mem_op(1, 1, 32'h418, 32'h5A5A5A5A, 32'h77777777, 32'h214);
        idle(1);
        check("both_we_cycles", 32'(we_cnt), 32'd5);
        check("both_oe_cycles", 32'(oe_cnt), 32'd0);
        check("both_dmem_kept", o_dmem, 32'h0BADF00D);

        // Address below the window wraps: (0 - 1024) >> 2 mod 2^17.
        mem_op(1, 0, 32'h0, 32'h0, 32'h13572468, 32'h218);
        idle(1);
        check("wrap_addr", 32'(o_sram_addr), 32'h1FF00);
        check("wrap_data", o_dmem, 32'h13572468);

        // Reset in ACCESS with count 2 (third access cycle).
        rd_en = 1; wr_en = 0; alu = 32'h420; sram_rdata = 32'h11111111; pc = 32'h21C;
        step(3);
        check("mid_oe_before", 32'(o_oe), 32'h1);
        reset = 1;
        step(1);
        check("mid_oe",     32'(o_oe), 32'h0);
        check("mid_freeze", 32'(o_freeze), 32'h0);
        check("mid_dmem",   o_dmem, 32'h0);
        reset = 0; rd_en = 0;
        idle(2);

        // Fresh load after the abandoned one.
        clr_counts();
        mem_op(1, 0, 32'h40C, 32'h0, 32'h2468ACE0, 32'h220);
        idle(1);
        check("post_rst_freeze_cycles", 32'(freeze_cnt), 32'd6);
        check("post_rst_data",          o_dmem, 32'h2468ACE0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the ARM pipeline. Sits between the EXE→MEM pipeline register and mem_stage_reg.
- Translates the ALU result into an SRAM word address and runs a multi-cycle SRAM access for loads and stores.
- Asserts o_Freeze to stall the upstream pipeline until the access completes.
- Passes the write-back control, destination and PC through to mem_stage_reg; the loaded word is presented on o_Data_Memory.

Parameters:
- DATA_WIDTH, 32, datapath width.
- ADDR_WIDTH, 17, SRAM word-address width.
- BASE_ADDRESS, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 5, SRAM access cycles per load or store; must be ≥1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- i_Pc  in  DATA_WIDTH  PC of the instruction in MEM
- i_Sig_Write_Back_Enable  in  1  WB enable from EXE reg
- i_Sig_Memory_Read_Enable  in  1  load request
- i_Sig_Memory_Write_Enable  in  1  store request
- i_ALU_Result  in  DATA_WIDTH  effective byte address / ALU value
- i_Val_Rm  in  DATA_WIDTH  store data
- i_Destination  in  4  destination register
- i_Sram_Read_Data  in  DATA_WIDTH  SRAM read data
- o_Pc  out  DATA_WIDTH  = i_Pc
- o_Sig_Write_Back_Enable  out  1  = i_Sig_Write_Back_Enable
- o_Sig_Memory_Read_Enable  out  1  = i_Sig_Memory_Read_Enable
- o_ALU_Result  out  DATA_WIDTH  = i_ALU_Result
- o_Destination  out  4  = i_Destination
- o_Data_Memory  out  DATA_WIDTH  registered load data
- o_Freeze  out  1  stall request to IF/ID/EXE stages and their pipeline registers
- o_Sram_Address  out  ADDR_WIDTH  registered SRAM word address
- o_Sram_Write_Data  out  DATA_WIDTH  registered store data
- o_Sram_Write_Enable  out  1  SRAM write strobe
- o_Sram_Output_Enable  out  1  SRAM read strobe

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high on reset.
- Pass-through outputs (o_Pc, o_Sig_*, o_ALU_Result, o_Destination) are combinational copies of the inputs. mem_stage_reg does the registering.
- Request definition: req = read_en | write_en. If both are asserted, the access is a write; o_Data_Memory is not updated.
- Address translation: word = (i_ALU_Result − BASE_ADDRESS) >> 2, truncated to ADDR_WIDTH bits. Low two address bits are ignored. Out-of-range addresses wrap modulo 2^ADDR_WIDTH; no fault is raised.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, req=1: latch address, write data and access type; clear counter; go to ACCESS.
  - IDLE, req=0: stay in IDLE.
  - ACCESS: counter increments each cycle. When counter == WAIT_CYCLES−1, go to DONE. If the access is a read, capture i_Sram_Read_Data into o_Data_Memory on that same edge.
  - DONE: go to IDLE unconditionally. This state exists so that the held request, still present during DONE, does not retrigger an access.
- Strobes: o_Sram_Output_Enable=1 only in ACCESS for reads. o_Sram_Write_Enable=1 only in ACCESS for writes. Both are 0 otherwise.
- o_Freeze = ~reset & ((IDLE & req) | ACCESS). It is combinational and is deasserted in DONE, so the pipeline advances on the DONE edge.
- Latency: request visible at cycle 0 → freeze high for cycles 0..WAIT_CYCLES → DONE at cycle WAIT_CYCLES+1. o_Data_Memory is valid from cycle WAIT_CYCLES+1 and holds until the next read capture.
- Non-memory instructions (req=0) incur no stall and leave o_Data_Memory unchanged.
- Back-to-back memory instructions: the second request is seen in IDLE on the cycle after DONE. Minimum spacing between accesses is therefore WAIT_CYCLES+2 cycles.
- Counter width: $clog2(WAIT_CYCLES+1).
- Reset values: state IDLE, counter 0, o_Data_Memory 0, o_Sram_Address 0, o_Sram_Write_Data 0, both strobes 0, o_Freeze 0.
- Reset mid-access: on the next edge the FSM returns to IDLE, strobes drop and o_Data_Memory clears to 0. The abandoned access has no further effect.

Test Plan:
- Reset: assert reset 2 cycles with read_en=1 → o_Freeze=0, both strobes 0, o_Data_Memory=0, FSM in IDLE after release.
- Load: WAIT_CYCLES=5, read_en=1, i_ALU_Result=0x408, i_Sram_Read_Data=0xDEADBEEF → o_Sram_Address=2, o_Freeze high 6 cycles, OE high 5 cycles, o_Data_Memory=0xDEADBEEF in DONE with o_Freeze=0.
- Store: write_en=1, i_ALU_Result=0x40C, i_Val_Rm=0x12345678 → address 3, WE high exactly 5 cycles with o_Sram_Write_Data=0x12345678, o_Data_Memory unchanged, o_Freeze high 6 cycles.
- Non-memory op: req=0, i_ALU_Result=0x55 → o_Freeze never asserted, strobes 0, pass-through outputs equal inputs in the same cycle.
- Back-to-back: load then store held on inputs → second access starts on the cycle after DONE; no DONE retrigger; total freeze cycles = 12.
- Reset mid-ACCESS at count 2 → strobes 0 and FSM in IDLE on the next edge; o_Data_Memory=0.
